// File: rtl/hazard_tracker_if.sv
// Hazard tracker ID-stage bundle: decoded ID instruction fields in, forwarding
// selects and pipeline control out. The master drives ID fields; the slave is
// the tracker.
interface hazard_tracker_if;
  logic       rs1use_ID;
  logic       rs2use_ID;
  logic [1:0] hazard_optype_ID;
  logic [4:0] rs1_ID;
  logic [4:0] rs2_ID;
  logic [4:0] rd_ID;
  logic       RegWrite_ID;
  logic       taken_ID;
  logic [1:0] forward_A;
  logic [1:0] forward_B;
  logic       PC_EN;
  logic       FD_EN;
  logic       FD_flush;
  logic       DE_flush;

  modport master (
    output rs1use_ID, rs2use_ID, hazard_optype_ID, rs1_ID, rs2_ID, rd_ID,
           RegWrite_ID, taken_ID,
    input  forward_A, forward_B, PC_EN, FD_EN, FD_flush, DE_flush
  );

  modport slave (
    input  rs1use_ID, rs2use_ID, hazard_optype_ID, rs1_ID, rs2_ID, rd_ID,
           RegWrite_ID, taken_ID,
    output forward_A, forward_B, PC_EN, FD_EN, FD_flush, DE_flush
  );
endinterface

// File: rtl/hazard_tracker.sv
// hazard_tracker: data-hazard detection and ID-stage forwarding control.
// Two tracking entries shadow the ID/EX and EX/MEM pipeline registers.
// A load whose result is needed by the very next instruction costs one
// stall cycle; afterwards the load data is forwarded from MEM.
// Optional macro HAZARD_STATS_EN adds 32-bit stall/flush event counters.
module hazard_tracker (
  input  logic              clk,
  input  logic              rst_n,
  hazard_tracker_if.slave   hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam logic [1:0] OP_LOAD    = 2'b00;
  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EX_ALU = 2'b01;
  localparam logic [1:0] FWD_MEM_AL = 2'b10;
  localparam logic [1:0] FWD_MEM_LD = 2'b11;

  // Tracking entries
  logic       r_ex_valid, r_ex_we, r_ex_load;
  logic [4:0] r_ex_rd;
  logic       r_mem_valid, r_mem_we, r_mem_load;
  logic [4:0] r_mem_rd;

  logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2;
  logic w_load_use;
  logic [1:0] w_fwd_a, w_fwd_b;

  // Source matching against each entry; x0 and unused operands never match
  always_comb begin
    w_ex_m1  = r_ex_valid  & r_ex_we  & (r_ex_rd  == hz.rs1_ID) & (r_ex_rd  != 5'd0) & hz.rs1use_ID;
    w_ex_m2  = r_ex_valid  & r_ex_we  & (r_ex_rd  == hz.rs2_ID) & (r_ex_rd  != 5'd0) & hz.rs2use_ID;
    w_mem_m1 = r_mem_valid & r_mem_we & (r_mem_rd == hz.rs1_ID) & (r_mem_rd != 5'd0) & hz.rs1use_ID;
    w_mem_m2 = r_mem_valid & r_mem_we & (r_mem_rd == hz.rs2_ID) & (r_mem_rd != 5'd0) & hz.rs2use_ID;
    w_load_use = (w_ex_m1 | w_ex_m2) & r_ex_load;
  end

  // Forward select per operand, EX result takes priority over MEM
  always_comb begin
    w_fwd_a = FWD_RF;
    if (w_ex_m1 && !r_ex_load)        w_fwd_a = FWD_EX_ALU;
    else if (w_mem_m1 && !r_mem_load) w_fwd_a = FWD_MEM_AL;
    else if (w_mem_m1 && r_mem_load)  w_fwd_a = FWD_MEM_LD;

    w_fwd_b = FWD_RF;
    if (w_ex_m2 && !r_ex_load)        w_fwd_b = FWD_EX_ALU;
    else if (w_mem_m2 && !r_mem_load) w_fwd_b = FWD_MEM_AL;
    else if (w_mem_m2 && r_mem_load)  w_fwd_b = FWD_MEM_LD;
  end

  // Pipeline control: a load-use stall overrides a taken redirect; the flush
  // is also masked while reset is held so control is quiet during reset.
  assign hz.forward_A = w_fwd_a;
  assign hz.forward_B = w_fwd_b;
  assign hz.PC_EN     = ~w_load_use;
  assign hz.FD_EN     = ~w_load_use;
  assign hz.DE_flush  = w_load_use;
  assign hz.FD_flush  = rst_n & hz.taken_ID & ~w_load_use;

  // Advance tracking entries; a stall inserts a bubble into EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_we     <= 1'b0;
      r_ex_load   <= 1'b0;
      r_ex_rd     <= 5'd0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_load  <= 1'b0;
      r_mem_rd    <= 5'd0;
    end else begin
      r_mem_valid <= r_ex_valid;
      r_mem_we    <= r_ex_we;
      r_mem_load  <= r_ex_load;
      r_mem_rd    <= r_ex_rd;
      if (w_load_use) begin
        r_ex_valid <= 1'b0;
        r_ex_we    <= 1'b0;
        r_ex_load  <= 1'b0;
        r_ex_rd    <= 5'd0;
      end else begin
        r_ex_valid <= 1'b1;
        r_ex_we    <= hz.RegWrite_ID;
        r_ex_load  <= (hz.hazard_optype_ID == OP_LOAD);
        r_ex_rd    <= hz.rd_ID;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  // Event counters, wrapping naturally at 32 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (w_load_use)  r_stall_cnt <= r_stall_cnt + 32'd1;
      if (hz.FD_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Scoreboard bench for hazard_tracker: stimulus pushes expected outputs into a
// queue, a negedge monitor pops and compares. Random instructions are checked
// against an in-flight instruction list; directed sequences use fixed values.
module tb_hazard_tracker;

  logic clk;
  logic rst_n;
  hazard_tracker_if hif ();
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_tracker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit [1:0]  fa, fb;
    bit        pc, fd, fdf, def;
    bit [31:0] sc, fc;
  } exp_t;

  // An instruction that has left ID; v=0 marks a bubble
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       we;
    bit       ld;
  } instr_t;

  exp_t   exp_q[$];
  instr_t inflight[$];   // index 0 = youngest (in EX), 1 = older (in MEM)
  bit [31:0] m_stall, m_flush;
  int n_tests, n_fail;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Operand source: walk the in-flight list youngest first and take the first
  // writer of rs. A load one slot ahead cannot forward yet (stall), so the
  // search continues to the older instruction.
  function automatic bit [1:0] src_of(bit use_, bit [4:0] rs, output bit hazard);
    hazard = 1'b0;
    if (!use_ || rs == 5'd0) return 2'd0;
    for (int age = 0; age < inflight.size(); age++) begin
      if (inflight[age].v && inflight[age].we && inflight[age].rd == rs) begin
        if (age == 0) begin
          if (inflight[age].ld) hazard = 1'b1;
          else return 2'd1;
        end else begin
          return inflight[age].ld ? 2'd3 : 2'd2;
        end
      end
    end
    return 2'd0;
  endfunction

  function automatic exp_t model(bit u1, bit u2, bit [4:0] r1, bit [4:0] r2, bit tk);
    exp_t e;
    bit h1, h2, stall;
    e.fa  = src_of(u1, r1, h1);
    e.fb  = src_of(u2, r2, h2);
    stall = h1 | h2;
    e.pc  = !stall;
    e.fd  = !stall;
    e.def = stall;
    e.fdf = tk && !stall;
    e.sc  = m_stall;
    e.fc  = m_flush;
    return e;
  endfunction

  // Drive one ID instruction, queue its expectation, then let the clock advance
  task automatic issue(bit u1, bit u2, bit [1:0] op, bit [4:0] r1, bit [4:0] r2,
                       bit [4:0] rd, bit we, bit tk,
                       bit fixed, bit [1:0] fa, bit [1:0] fb, bit stall, bit fdf);
    exp_t e;
    instr_t ni;
    hif.rs1use_ID = u1;  hif.rs2use_ID = u2;  hif.hazard_optype_ID = op;
    hif.rs1_ID = r1;     hif.rs2_ID = r2;     hif.rd_ID = rd;
    hif.RegWrite_ID = we; hif.taken_ID = tk;
    e = model(u1, u2, r1, r2, tk);
    if (fixed) begin
      e.fa = fa; e.fb = fb;
      e.pc = !stall; e.fd = !stall; e.def = stall; e.fdf = fdf;
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (e.def) m_stall++;
    if (e.fdf) m_flush++;
    ni.v = !e.def; ni.rd = rd; ni.we = we && !e.def; ni.ld = (op == 2'b00);
    inflight.push_front(ni);
    if (inflight.size() > 2) void'(inflight.pop_back());
    #1;
  endtask

  task automatic nop();
    issue(0, 0, 2'b11, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 0);
  endtask

  task automatic check_idle_outputs(string tag);
    chk({tag, "_fwdA"}, hif.forward_A, 2'd0);
    chk({tag, "_fwdB"}, hif.forward_B, 2'd0);
    chk({tag, "_PC_EN"}, hif.PC_EN, 1'b1);
    chk({tag, "_FD_EN"}, hif.FD_EN, 1'b1);
    chk({tag, "_FD_flush"}, hif.FD_flush, 1'b0);
    chk({tag, "_DE_flush"}, hif.DE_flush, 1'b0);
`ifdef HAZARD_STATS_EN
    chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
    chk({tag, "_flush_cnt"}, flush_cnt, 32'd0);
`endif
  endtask

  // Monitor: outputs are valid every cycle; compare once per queued entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("forward_A", hif.forward_A, e.fa);
        chk("forward_B", hif.forward_B, e.fb);
        chk("PC_EN", hif.PC_EN, e.pc);
        chk("FD_EN", hif.FD_EN, e.fd);
        chk("FD_flush", hif.FD_flush, e.fdf);
        chk("DE_flush", hif.DE_flush, e.def);
`ifdef HAZARD_STATS_EN
        chk("stall_cnt", stall_cnt, e.sc);
        chk("flush_cnt", flush_cnt, e.fc);
`endif
        $display("[TB] t=%0t fa=%0d fb=%0d pc=%0b fd=%0b fdf=%0b def=%0b",
                 $time, hif.forward_A, hif.forward_B, hif.PC_EN, hif.FD_EN,
                 hif.FD_flush, hif.DE_flush);
      end
    end
  end

  initial begin
    n_tests = 0; n_fail = 0; m_stall = 0; m_flush = 0;
    // Busy ID inputs during reset: outputs must still be quiet
    rst_n = 1'b0;
    hif.rs1use_ID = 1; hif.rs2use_ID = 1; hif.hazard_optype_ID = 2'b10;
    hif.rs1_ID = 5'd1; hif.rs2_ID = 5'd2; hif.rd_ID = 5'd3;
    hif.RegWrite_ID = 0; hif.taken_ID = 1;
    #12;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    hif.taken_ID = 0;
    #1;
    check_idle_outputs("post_reset");

    // Load-use: lw x5 ; add x6,x5,x7 stalls once, then forwards load data
    nop(); nop();
    issue(1, 0, 2'b00, 0, 0, 5, 1, 0, 1, 2'd0, 2'd0, 0, 0);
    issue(1, 1, 2'b01, 5, 7, 6, 1, 0, 1, 2'd0, 2'd0, 1, 0);
    issue(1, 1, 2'b01, 5, 7, 6, 1, 0, 1, 2'd3, 2'd0, 0, 0);

    // Back-to-back ALU dependency, then with a gap
    nop(); nop();
    issue(1, 1, 2'b01, 1, 2, 3, 1, 0, 1, 2'd0, 2'd0, 0, 0);
    issue(1, 1, 2'b01, 3, 3, 4, 1, 0, 1, 2'd1, 2'd1, 0, 0);
    nop(); nop();
    issue(1, 1, 2'b01, 1, 2, 3, 1, 0, 1, 2'd0, 2'd0, 0, 0);
    nop();
    issue(1, 1, 2'b01, 3, 3, 4, 1, 0, 1, 2'd2, 2'd2, 0, 0);

    // x0 writes never forward
    nop(); nop();
    issue(1, 0, 2'b11, 0, 0, 0, 1, 0, 1, 2'd0, 2'd0, 0, 0);
    issue(1, 1, 2'b01, 0, 0, 1, 1, 0, 1, 2'd0, 2'd0, 0, 0);

    // lw x8 ; beq x8,x9 taken: stall wins, then flush with forwarded load
    nop(); nop();
    issue(1, 0, 2'b00, 0, 0, 8, 1, 0, 1, 2'd0, 2'd0, 0, 0);
    issue(1, 1, 2'b10, 8, 9, 0, 0, 1, 1, 2'd0, 2'd0, 1, 0);
    issue(1, 1, 2'b10, 8, 9, 0, 0, 1, 1, 2'd3, 2'd0, 0, 1);

    // Store (RegWrite=0) never creates a later match
    nop(); nop();
    issue(1, 1, 2'b11, 1, 10, 10, 0, 0, 1, 2'd0, 2'd0, 0, 0);
    issue(1, 1, 2'b01, 10, 10, 11, 1, 0, 1, 2'd0, 2'd0, 0, 0);

    // Randomized instruction stream over a small register set
    for (int i = 0; i < 400; i++) begin
      bit [1:0] op;
      bit we;
      op = 2'($urandom_range(0, 3));
      we = (op == 2'b10) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      issue(1'($urandom), 1'($urandom), op,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), we, 1'($urandom_range(0, 3) == 0),
            0, 2'd0, 2'd0, 0, 0);
    end

`ifdef HAZARD_STATS_EN
    // Counter wrap: preload stall count to all ones, then one load-use stall
    nop(); nop();
    force dut.r_stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_cnt;
    m_stall = 32'hFFFF_FFFF;
    issue(1, 0, 2'b00, 0, 0, 5, 1, 0, 1, 2'd0, 2'd0, 0, 0);
    issue(1, 1, 2'b01, 5, 7, 6, 1, 0, 1, 2'd0, 2'd0, 1, 0);
    issue(1, 1, 2'b01, 5, 7, 6, 1, 0, 1, 2'd3, 2'd0, 0, 0);
    chk("stall_cnt_wrap", stall_cnt, 32'd0);
`endif

    // Reset asserted in the middle of a stall cycle
    nop(); nop();
    issue(1, 0, 2'b00, 0, 0, 5, 1, 0, 1, 2'd0, 2'd0, 0, 0);
    hif.rs1use_ID = 1; hif.rs2use_ID = 1; hif.hazard_optype_ID = 2'b01;
    hif.rs1_ID = 5'd5; hif.rs2_ID = 5'd7; hif.rd_ID = 5'd6;
    hif.RegWrite_ID = 1; hif.taken_ID = 0;
    #1;
    chk("midstall_PC_EN", hif.PC_EN, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_midstall");
    @(posedge clk); #1;
    rst_n = 1'b1;
    inflight.delete();
    m_stall = 0; m_flush = 0;
    issue(1, 1, 2'b01, 5, 7, 6, 1, 0, 1, 2'd0, 2'd0, 0, 0);
    nop();

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
